// File: rtl/qs_fifo_pkg.sv
// Shared types and defaults for the qs_fifo family of blocks.
// Holds the reader FSM encoding and the default word width.
package qs_fifo_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    function automatic logic occ_full(input logic [1:0] occ);
        return occ == 2'd2;
    endfunction

endpackage

// File: rtl/qs_skid_buf.sv
// Two-entry in-order buffer; entry 0 is the head and is presented registered.
// A read shifts entry 1 down; a write lands at the first free slot after that shift.
module qs_skid_buf
    import qs_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              clr,
    output logic [1:0]        occ,
    output logic [DATA_W-1:0] head_data,
    output logic              valid
);

    logic [1:0]        occ_reg;
    logic [1:0]        occ_next;
    logic              rd_eff;
    logic              wr_eff;
    logic [1:0]        wr_idx;
    logic [DATA_W-1:0] entry_data [2];
    logic [DATA_W-1:0] shift_src  [2];

    assign rd_eff = rd_en && (occ_reg != 2'd0);
    assign wr_eff = wr_en && (!occ_full(occ_reg) || rd_eff);
    assign wr_idx = occ_reg - {1'b0, rd_eff};

    always_comb begin
        occ_next = occ_reg;
        if (clr) begin
            occ_next = 2'd0;
        end else if (wr_eff && !rd_eff) begin
            occ_next = occ_reg + 2'd1;
        end else if (rd_eff && !wr_eff) begin
            occ_next = occ_reg - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_reg <= 2'd0;
        end else begin
            occ_reg <= occ_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [DATA_W-1:0] data_reg;

            // The tail entry has nothing behind it, so a read leaves it as is.
            if (gi == 0) begin : g_shift_head
                assign shift_src[gi] = entry_data[1];
            end else begin : g_shift_tail
                assign shift_src[gi] = data_reg;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    data_reg <= '0;
                end else if (!clr) begin
                    if (wr_eff && (wr_idx == 2'(gi))) begin
                        data_reg <= wr_data;
                    end else if (rd_eff) begin
                        data_reg <= shift_src[gi];
                    end
                end
            end

            assign entry_data[gi] = data_reg;
        end
    endgenerate

    assign occ       = occ_reg;
    assign head_data = entry_data[0];
    assign valid     = (occ_reg != 2'd0);

endmodule

// File: rtl/qs_fifo_reader.sv
// Read-side controller for qs_fifo: pops into a 2-entry buffer, streams it out
// on valid/ready, supports enable, flush-to-empty and a saturating pop counter.
module qs_fifo_reader
    import qs_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              flush_i,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_pop_data_i,
    output logic              fifo_pop_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              busy_o,
    output logic              flush_done_o,
    output logic [CNT_W-1:0]  pop_count_o
);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] pop_count_reg;
    logic [1:0]       occ;
    logic             buf_valid;
    logic             buf_clr;
    logic             buf_wr;
    logic             buf_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Popping in RUN is suppressed on the flush request cycle so that the
    // flush discards exactly what the FIFO holds from the next cycle on.
    always_comb begin
        state_next   = state_reg;
        fifo_pop_o   = 1'b0;
        flush_done_o = 1'b0;
        buf_clr      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (flush_i) begin
                    state_next = ST_FLUSH;
                    buf_clr    = 1'b1;
                end else if (en_i) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    state_next = ST_FLUSH;
                    buf_clr    = 1'b1;
                end else begin
                    fifo_pop_o = en_i && !fifo_empty_i && !occ_full(occ);
                    if (!en_i) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                fifo_pop_o = !fifo_empty_i;
                if (fifo_empty_i) begin
                    state_next   = ST_IDLE;
                    flush_done_o = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign buf_wr = fifo_pop_o && (state_reg == ST_RUN);
    assign buf_rd = buf_valid && out_ready_i;

    qs_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (buf_wr),
        .wr_data   (fifo_pop_data_i),
        .rd_en     (buf_rd),
        .clr       (buf_clr),
        .occ       (occ),
        .head_data (out_data_o),
        .valid     (buf_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pop_count_reg <= '0;
        end else if (fifo_pop_o && (pop_count_reg != '1)) begin
            pop_count_reg <= pop_count_reg + 1'b1;
        end
    end

    assign out_valid_o = buf_valid;
    assign busy_o      = (state_reg != ST_IDLE) || buf_valid;
    assign pop_count_o = pop_count_reg;

endmodule
